uart_boot_loader: RTL and testbench

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_loader_pkg.sv | 28 ++
 rtl/uart_boot_loader_rx.sv | 95 +++++++++
 rtl/uart_boot_loader.sv | 132 +++++++++++++
 tb/tb_uart_boot_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader and its serial receiver.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    RUN
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         UART_DATA_BITS = 8;

  // A word count is usable when it is non-zero and fits the instruction memory.
  function automatic logic len_ok(input logic [15:0] n, input int addr_w);
    return (n != 16'd0) && (32'(n) <= (32'(1) << addr_w));
  endfunction

endpackage

// File: rtl/uart_boot_loader_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling, one-cycle byte_valid
// pulse on a good stop bit and a one-cycle frame_err pulse on a bad one.
module uart_rx
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int              CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      LAST_BIT = 3'(UART_DATA_BITS - 1);

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  assign byte_data = shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Timing is counted from the synchronized falling edge, so the fixed
  // synchronizer delay shifts every sample point equally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_CNT) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_CNT) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[7:1]};
            if (bit_idx == LAST_BIT) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_CNT) begin
            cnt        <= '0;
            state      <= RX_IDLE;
            byte_valid <= rx_sync;
            frame_err  <= !rx_sync;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: receives sync, length, program words and checksum over
// UART, writes the words to instruction memory and then releases the core.
module uart_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMEM_ADDR_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   core_run,
  output logic                   load_busy,
  output logic                   load_error
);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        frame_err;

  boot_state_t state;
  logic [7:0]  len_lo;
  logic [7:0]  checksum;
  logic [16:0] word_total;
  logic [16:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [15:0] rx_len;

  assign rx_len = {rx_byte, len_lo};

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_data (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // Framing FSM. The cycle after a write strobe either advances the address
  // or, after the last word, moves on to the checksum byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_SYNC;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_run   <= 1'b0;
      load_busy  <= 1'b0;
      load_error <= 1'b0;
      len_lo     <= '0;
      checksum   <= '0;
      word_total <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (frame_err && state != RUN) begin
        load_error <= 1'b1;
        load_busy  <= 1'b0;
        state      <= WAIT_SYNC;
      end else if (imem_we) begin
        if (word_cnt == word_total) state <= CHECK;
        else imem_addr <= imem_addr + 1'b1;
      end else if (byte_valid) begin
        case (state)
          WAIT_SYNC: begin
            if (rx_byte == SYNC_BYTE) begin
              load_error <= 1'b0;
              load_busy  <= 1'b1;
              checksum   <= '0;
              imem_addr  <= '0;
              word_cnt   <= '0;
              byte_idx   <= '0;
              state      <= LEN_LO;
            end
          end
          LEN_LO: begin
            len_lo   <= rx_byte;
            checksum <= checksum ^ rx_byte;
            state    <= LEN_HI;
          end
          LEN_HI: begin
            checksum <= checksum ^ rx_byte;
            if (len_ok(rx_len, IMEM_ADDR_W)) begin
              word_total <= {1'b0, rx_len};
              state      <= DATA;
            end else begin
              load_error <= 1'b1;
              load_busy  <= 1'b0;
              state      <= WAIT_SYNC;
            end
          end
          DATA: begin
            checksum <= checksum ^ rx_byte;
            byte_idx <= byte_idx + 1'b1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_byte;
              2'd1: word_buf[15:8]  <= rx_byte;
              2'd2: word_buf[23:16] <= rx_byte;
              default: begin
                imem_we    <= 1'b1;
                imem_wdata <= {rx_byte, word_buf};
                word_cnt   <= word_cnt + 1'b1;
              end
            endcase
          end
          CHECK: begin
            load_busy <= 1'b0;
            if (rx_byte == checksum) begin
              core_run <= 1'b1;
              state    <= RUN;
            end else begin
              load_error <= 1'b1;
              state      <= WAIT_SYNC;
            end
          end
          RUN: ;
          default: state <= WAIT_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: serial byte stimulus, write scoreboard
// and immediate-assertion checks on the control outputs.
module tb_uart_boot_loader;

  localparam int CLKS = 4;
  localparam int AW   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_run;
  logic          load_busy;
  logic          load_error;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] prog[2];

  uart_boot_loader #(
    .CLKS_PER_BIT(CLKS),
    .IMEM_ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_run  (core_run),
    .load_busy (load_busy),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Serial frame of one byte, optionally with a low stop bit, plus idle time.
  task automatic applyStimulus(input logic [7:0] b, input bit bad_stop = 1'b0);
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
    rx = !bad_stop;
    repeat (CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ctrl"}, 32'({imem_we, core_run, load_busy, load_error}), 32'h0);
    checkOutput({tag, "_addr"}, 32'(imem_addr), 32'h0);
    checkOutput({tag, "_wdata"}, imem_wdata, 32'h0);
  endtask

  task automatic resetPulse(input string tag);
    reset = 1'b0;
    #1;
    checkReset(tag);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full load of prog[]; cs_flip corrupts the checksum byte when non-zero.
  task automatic loadProgram(input logic [7:0] cs_flip, input string tag);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h02 ^ 8'h00;
    for (int w = 0; w < 2; w++) exp_q.push_back('{addr: AW'(w), data: prog[w]});
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = prog[w][8*k +: 8];
        cs = cs ^ b;
        applyStimulus(b);
      end
    end
    checkOutput({tag, "_busy_pre"}, 32'(load_busy), 32'h1);
    checkOutput({tag, "_run_pre"}, 32'(core_run), 32'h0);
    applyStimulus(cs ^ cs_flip);
  endtask

  task automatic checkRunState(input string tag, input logic run, input logic err);
    checkOutput({tag, "_run"}, 32'(core_run), 32'(run));
    checkOutput({tag, "_busy"}, 32'(load_busy), 32'h0);
    checkOutput({tag, "_err"}, 32'(load_error), 32'(err));
  endtask

  always @(negedge clk) begin
    if (reset && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("[TB] FAIL unexpected_write observed addr=0x%02h data=0x%08h expected no write",
               imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("write_addr", 32'(imem_addr), 32'(e.addr));
        checkOutput("write_data", imem_wdata, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    repeat (3) @(negedge clk);
    checkReset("reset_state");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] noise bytes then good load");
    applyStimulus(8'h55);
    applyStimulus(8'hFF);
    checkOutput("noise_busy", 32'(load_busy), 32'h0);
    checkOutput("noise_err", 32'(load_error), 32'h0);
    loadProgram(8'h00, "good1");
    checkRunState("good1", 1'b1, 1'b0);

    $display("[TB] rx ignored while running");
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h00, 1'b1);
    checkRunState("run_hold", 1'b1, 1'b0);
    resetPulse("run_reset");

    $display("[TB] bad checksum");
    loadProgram(8'h03, "badcs");
    checkRunState("badcs", 1'b0, 1'b1);

    $display("[TB] length boundaries");
    applyStimulus(8'hA5);
    checkOutput("sync_clears_err", 32'(load_error), 32'h0);
    checkOutput("sync_sets_busy", 32'(load_busy), 32'h1);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkRunState("len_zero", 1'b0, 1'b1);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    checkRunState("len_257", 1'b0, 1'b1);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    checkOutput("len_256_busy", 32'(load_busy), 32'h1);
    checkOutput("len_256_err", 32'(load_error), 32'h0);
    resetPulse("len_reset");

    $display("[TB] framing error in third data byte");
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h13);
    applyStimulus(8'h00);
    applyStimulus(8'h00, 1'b1);
    checkRunState("frame_err", 1'b0, 1'b1);
    loadProgram(8'h00, "after_frame");
    checkRunState("after_frame", 1'b1, 1'b0);
    resetPulse("frame_reset");

    $display("[TB] reset in the middle of word 1");
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h13);
    applyStimulus(8'h00);
    checkOutput("midload_busy", 32'(load_busy), 32'h1);
    resetPulse("midload_reset");
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("post_reset_busy", 32'(load_busy), 32'h0);
    loadProgram(8'h00, "reload");
    checkRunState("reload", 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    checkOutput("writes_outstanding", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
